game_timer: RTL and testbench

//  Countdown game clock: the producer of the gameover level that the score display consumes.
//  - Loads a BCD start time and decrements it once per prescaled second.
//  - Exposes 3 BCD digits for the hex display decoders.
//  - Asserts gameover when the time reaches 000 and holds it until restart or reset.

---
 rtl/game_timer.sv | 164 ++++++++++++++++
 tb/tb_game_timer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/game_timer.sv
// game_timer: countdown game clock with BCD time, prescaled second tick and
// gameover level for the score display.
// Optional feature macro: GAME_TIMER_BONUS_EN (bonus pulse adds BONUS_BCD,
// saturating at 999). Without it the bonus input is ignored.
module game_timer #(
  parameter int          DIV_COUNT = 50_000_000,
  parameter logic [11:0] START_BCD = 12'h060,
  parameter logic [11:0] BONUS_BCD = 12'h005
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        bonus,
  output logic [11:0] bcd_out,
  output logic        sec_tick,
  output logic        running,
  output logic        gameover
);

  localparam int            PW         = $clog2(DIV_COUNT);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV_COUNT - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [11:0]   bcd_q;
  logic          tick_q;
  logic          running_q;
  logic          gameover_q;

  logic [11:0]   dec_val;
  logic [11:0]   add_val;
  logic [11:0]   dec_add_val;
  logic          bonus_hit;

  // BCD decrement with borrow; callers never pass 000
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    h = v[11:8];
    t = v[7:4];
    o = v[3:0];
    if (o != 4'd0) begin
      o = o - 4'd1;
    end else begin
      o = 4'd9;
      if (t != 4'd0) begin
        t = t - 4'd1;
      end else begin
        t = 4'd9;
        h = h - 4'd1;
      end
    end
    return {h, t, o};
  endfunction

  // BCD add with carry, clamped to 999 when the hundreds digit overflows
  function automatic logic [11:0] bcd_add_sat(input logic [11:0] a, input logic [11:0] b);
    logic [4:0]  s;
    logic        c;
    logic [11:0] r;
    c = 1'b0;
    r = 12'h000;
    for (int i = 0; i < 3; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
      if (s > 5'd9) begin
        s = s - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i +: 4] = s[3:0];
    end
    if (c) begin
      r = 12'h999;
    end
    return r;
  endfunction

  assign dec_val     = bcd_dec(bcd_q);
  assign add_val     = bcd_add_sat(bcd_q, BONUS_BCD);
  assign dec_add_val = bcd_add_sat(dec_val, BONUS_BCD);

`ifdef GAME_TIMER_BONUS_EN
  assign bonus_hit = bonus;
`else
  logic bonus_unused;
  assign bonus_unused = bonus;
  assign bonus_hit    = 1'b0;
`endif

  // Control FSM: start reloads, pause freezes the prescaler, ticks decrement time
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bcd_q      <= START_BCD;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
      gameover_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (start) begin
        bcd_q   <= START_BCD;
        presc_q <= '0;
        if (START_BCD == 12'h000) begin
          state_q    <= EXPIRED;
          running_q  <= 1'b0;
          gameover_q <= 1'b1;
        end else begin
          state_q    <= RUN;
          running_q  <= 1'b1;
          gameover_q <= 1'b0;
        end
      end else begin
        case (state_q)
          RUN: begin
            if (pause) begin
              state_q   <= PAUSED;
              running_q <= 1'b0;
              if (bonus_hit) bcd_q <= add_val;
            end else if (presc_q == PRESC_LAST) begin
              presc_q <= '0;
              tick_q  <= 1'b1;
              if (bonus_hit) begin
                // Combined tick and bonus is one update and cannot reach 000
                bcd_q <= dec_add_val;
              end else begin
                bcd_q <= dec_val;
                if (dec_val == 12'h000) begin
                  state_q    <= EXPIRED;
                  running_q  <= 1'b0;
                  gameover_q <= 1'b1;
                end
              end
            end else begin
              presc_q <= presc_q + PW'(1);
              if (bonus_hit) bcd_q <= add_val;
            end
          end
          PAUSED: begin
            if (!pause) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
            if (bonus_hit) bcd_q <= add_val;
          end
          default: begin
            // IDLE and EXPIRED hold until start or reset
          end
        endcase
      end
    end
  end

  assign bcd_out  = bcd_q;
  assign sec_tick = tick_q;
  assign running  = running_q;
  assign gameover = gameover_q;

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer with DIV_COUNT=4; four instances differ only
// in START_BCD (060, 010, 100, 998) and share all inputs.
module tb_game_timer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic bonus = 1'b0;

  logic [11:0] bcd_060, bcd_010, bcd_100, bcd_998;
  logic tick_060, tick_010, tick_100, tick_998;
  logic run_060, run_010, run_100, run_998;
  logic go_060, go_010, go_100, go_998;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  game_timer #(.DIV_COUNT(4), .START_BCD(12'h060), .BONUS_BCD(12'h005)) u_t060 (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .bonus(bonus),
    .bcd_out(bcd_060), .sec_tick(tick_060), .running(run_060), .gameover(go_060));
  game_timer #(.DIV_COUNT(4), .START_BCD(12'h010), .BONUS_BCD(12'h005)) u_t010 (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .bonus(bonus),
    .bcd_out(bcd_010), .sec_tick(tick_010), .running(run_010), .gameover(go_010));
  game_timer #(.DIV_COUNT(4), .START_BCD(12'h100), .BONUS_BCD(12'h005)) u_t100 (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .bonus(bonus),
    .bcd_out(bcd_100), .sec_tick(tick_100), .running(run_100), .gameover(go_100));
  game_timer #(.DIV_COUNT(4), .START_BCD(12'h998), .BONUS_BCD(12'h005)) u_t998 (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .bonus(bonus),
    .bcd_out(bcd_998), .sec_tick(tick_998), .running(run_998), .gameover(go_998));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (bcd_060 !== 12'h060) begin errors++; $display("FAIL reset_bcd got=%h exp=060", bcd_060); end
    checks++; if (go_060 !== 1'b0) begin errors++; $display("FAIL reset_gameover got=%b exp=0", go_060); end
    checks++; if (run_060 !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", run_060); end
    checks++; if (tick_060 !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick_060); end
    reset = 1'b0;
    pause = 1'b1;
    for (int i = 0; i < 8; i++) step();
    pause = 1'b0;
    checks++; if (bcd_060 !== 12'h060 || run_060 !== 1'b0) begin
      errors++; $display("FAIL idle_hold got=%h/%b exp=060/0", bcd_060, run_060);
    end
  endtask

  task automatic test_countdown();
    int nt;
    int bad;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (run_010 !== 1'b1 || bcd_010 !== 12'h010) begin
      errors++; $display("FAIL start_run got=%b/%h exp=1/010", run_010, bcd_010);
    end
    nt = 0;
    bad = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (tick_010 === 1'b1) nt++;
      if (tick_010 !== ((i % 4) == 0)) bad++;
      if (i == 4) begin
        checks++; if (bcd_010 !== 12'h009) begin errors++; $display("FAIL borrow_dec got=%h exp=009", bcd_010); end
      end
    end
    checks++; if (nt !== 10) begin errors++; $display("FAIL tick_count got=%0d exp=10", nt); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL tick_spacing got=%0d exp=0", bad); end
    checks++; if (bcd_010 !== 12'h000) begin errors++; $display("FAIL expire_bcd got=%h exp=000", bcd_010); end
    checks++; if (go_010 !== 1'b1 || run_010 !== 1'b0) begin
      errors++; $display("FAIL expire_flags got=%b/%b exp=1/0", go_010, run_010);
    end
    pause = 1'b1;
    nt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (tick_010 !== 1'b0) nt++;
    end
    pause = 1'b0;
    checks++; if (go_010 !== 1'b1 || bcd_010 !== 12'h000 || nt !== 0) begin
      errors++; $display("FAIL expired_hold got=%b/%h/%0d exp=1/000/0", go_010, bcd_010, nt);
    end
  endtask

  task automatic test_restart();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (bcd_010 !== 12'h010 || go_010 !== 1'b0 || run_010 !== 1'b1) begin
      errors++; $display("FAIL restart got=%h/%b/%b exp=010/0/1", bcd_010, go_010, run_010);
    end
    for (int i = 0; i < 5; i++) step();
    checks++; if (bcd_010 !== 12'h009) begin errors++; $display("FAIL restart_dec got=%h exp=009", bcd_010); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bcd_010 !== 12'h010 || run_010 !== 1'b0 || go_010 !== 1'b0 || tick_010 !== 1'b0) begin
      errors++; $display("FAIL midrun_reset got=%h/%b/%b/%b exp=010/0/0/0", bcd_010, run_010, go_010, tick_010);
    end
  endtask

  task automatic test_tick_pause();
    int nt;
    int bad;
    start = 1'b1;
    step();
    start = 1'b0;
    nt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (tick_100 === 1'b1) nt++;
    end
    checks++; if (bcd_100 !== 12'h099) begin errors++; $display("FAIL hundred_borrow got=%h exp=099", bcd_100); end
    checks++; if (nt !== 1) begin errors++; $display("FAIL single_tick got=%0d exp=1", nt); end
    step();
    step();
    pause = 1'b1;
    nt = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick_100 !== 1'b0) nt++;
      if (bcd_100 !== 12'h099) bad++;
    end
    checks++; if (nt !== 0 || bad !== 0) begin
      errors++; $display("FAIL pause_freeze got=ticks%0d/bcdbad%0d exp=0/0", nt, bad);
    end
    checks++; if (run_100 !== 1'b0) begin errors++; $display("FAIL paused_running got=%b exp=0", run_100); end
    pause = 1'b0;
    step();
    checks++; if (tick_100 !== 1'b0 || run_100 !== 1'b1) begin
      errors++; $display("FAIL resume_1 got=%b/%b exp=0/1", tick_100, run_100);
    end
    step();
    checks++; if (tick_100 !== 1'b0) begin errors++; $display("FAIL resume_2 got=%b exp=0", tick_100); end
    step();
    checks++; if (tick_100 !== 1'b1 || bcd_100 !== 12'h098) begin
      errors++; $display("FAIL resume_tick got=%b/%h exp=1/098", tick_100, bcd_100);
    end
  endtask

  task automatic test_bonus();
    logic [11:0] exp_sat;
    logic [11:0] exp_tick010;
    logic [11:0] exp_tick998;
`ifdef GAME_TIMER_BONUS_EN
    exp_sat     = 12'h999;
    exp_tick010 = 12'h014;
    exp_tick998 = 12'h999;
`else
    exp_sat     = 12'h998;
    exp_tick010 = 12'h009;
    exp_tick998 = 12'h997;
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    bonus = 1'b1;
    step();
    bonus = 1'b0;
    checks++; if (bcd_010 !== 12'h010 || run_010 !== 1'b0) begin
      errors++; $display("FAIL bonus_idle got=%h/%b exp=010/0", bcd_010, run_010);
    end
    start = 1'b1;
    bonus = 1'b1;
    step();
    start = 1'b0;
    bonus = 1'b0;
    checks++; if (bcd_010 !== 12'h010) begin errors++; $display("FAIL bonus_start got=%h exp=010", bcd_010); end
    bonus = 1'b1;
    step();
    bonus = 1'b0;
    checks++; if (bcd_998 !== exp_sat) begin errors++; $display("FAIL bonus_sat got=%h exp=%h", bcd_998, exp_sat); end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    bonus = 1'b1;
    step();
    bonus = 1'b0;
    checks++; if (tick_010 !== 1'b1 || bcd_010 !== exp_tick010) begin
      errors++; $display("FAIL bonus_tick got=%b/%h exp=1/%h", tick_010, bcd_010, exp_tick010);
    end
    checks++; if (bcd_998 !== exp_tick998) begin
      errors++; $display("FAIL bonus_tick_sat got=%h exp=%h", bcd_998, exp_tick998);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_restart();
    test_tick_pause();
    test_bonus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
